fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8: program counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 8: instruction width; the opcode is instr_out[INSTR_W-1:INSTR_W-3].
REQ-003 SHALL have parameter STACK_DEPTH, default 4: number of return-stack entries.
REQ-004 SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have fetch_req, output, 1: instruction-memory read request.
REQ-007 SHALL have pc, output, PC_W: current fetch address.
REQ-008 SHALL have instr_ready, input, 1: instruction memory returns instr_rdata this cycle.
REQ-009 SHALL have instr_rdata, input, INSTR_W: fetched instruction.
REQ-010 SHALL have instr_valid, output, 1: one-cycle pulse; instr_out is presented to the decoder.
REQ-011 SHALL have instr_out, output, INSTR_W: registered instruction.
REQ-012 SHALL have jmp, input, 1: decoder jump strobe, sampled only while instr_valid=1.
REQ-013 SHALL have ret, input, 1: decoder return strobe, sampled only while instr_valid=1.
REQ-014 SHALL have target, input, PC_W: jump destination, sampled with jmp.
REQ-015 SHALL have stack_err, output, 1: sticky overflow/underflow/illegal-strobe flag.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH and EXEC; rst forces IDLE; IDLE always goes to FETCH next cycle.
REQ-017 SHALL hold fetch_req=1 with a stable pc in FETCH until instr_ready=1, then capture instr_rdata into instr_out and enter EXEC.
REQ-018 SHALL hold fetch_req=0 in IDLE and EXEC, and ignore instr_ready outside FETCH.
REQ-019 SHALL drive instr_valid=1 for exactly the one EXEC cycle, then return to FETCH; minimum 2 cycles per instruction.
REQ-020 SHALL, in EXEC with jmp=1 and ret=0, push pc+1 onto the return stack and load pc with target.
REQ-021 SHALL, in EXEC with ret=1 and jmp=0, pop the top entry into pc.
REQ-022 SHALL, in EXEC with neither strobe high, load pc with pc+1, wrapping 2^PC_W-1 to 0.
REQ-023 SHALL, on jmp with the stack full, still take the jump, discard the push and set stack_err.
REQ-024 SHALL, on ret with the stack empty, load pc with pc+1 and set stack_err.
REQ-025 SHALL, with jmp and ret both high, treat the instruction as illegal: load pc with pc+1, leave the stack unchanged, set stack_err.
REQ-026 SHALL hold stack_err at 1 until rst.

Reset
REQ-027 SHALL, on rst, set pc=0, instr_out=0, instr_valid=0, fetch_req=0, stack_err=0, stack pointer=0 and state IDLE.
REQ-028 SHALL, when rst arrives mid-FETCH or mid-EXEC, abandon the in-flight instruction with no push or pop, and ignore instr_ready in the reset cycle.

Configuration
REQ-029 SHALL, with macro FETCH_RET_STACK_EN defined, implement the STACK_DEPTH-entry LIFO return stack described in REQ-020 to REQ-025.
REQ-030 SHALL, without FETCH_RET_STACK_EN, replace the stack with a single link register plus a valid bit: jmp overwrites the link and sets valid; jmp never flags overflow; ret with valid=0 behaves as REQ-024; ret with valid=1 clears valid.

Structure
REQ-031 SHALL place the FSM state encoding, the opcode constants (LOAD_A=000, LOAD_B=001, STORE=010, STORE_IMM=011, JMP=100, RET=110, ALU=111) and the PC_W/INSTR_W defaults in shared package fetch_pkg.
REQ-032 SHALL implement the return stack as sub-module ret_stack with push, pop, din, dout, full, empty; the macro selects its depth-1 link variant.

Verification
REQ-033 SHALL cover sequential fetch: after reset, instr_ready=1 every FETCH cycle -> pc sequence 0,1,2,... and instr_valid pulses every 2nd cycle.
REQ-034 SHALL cover memory stall: instr_ready held 0 for 5 cycles at pc=3 -> fetch_req=1, pc=3 throughout, no instr_valid pulse.
REQ-035 SHALL cover call/return: jmp with target=0x40 at pc=0x10, then ret at pc=0x40 -> pc goes 0x40, then 0x11; stack_err=0.
REQ-036 SHALL cover overflow/underflow: 5 nested jmps (depth 4) -> stack_err=1 on the 5th while the jump is still taken; ret on an empty stack at pc=0x20 -> pc=0x21, stack_err=1.
REQ-037 SHALL cover wrap and reset: pc=0xFF with no strobe -> pc=0x00; rst asserted in EXEC -> next cycle pc=0, IDLE, stack empty.
REQ-038 SHALL cover both strobes: jmp=ret=1 at pc=0x08 -> pc=0x09, stack unchanged, stack_err=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared FSM state encoding, opcode constants and width
//                defaults for the fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    localparam int c_PC_W_DEFAULT    = 8;
    localparam int c_INSTR_W_DEFAULT = 8;

    localparam int         c_STATE_W  = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_EXEC  = 2'd2;

    // Opcode lives in the top three bits of the instruction word.
    localparam logic [2:0] c_OP_LOAD_A    = 3'b000;
    localparam logic [2:0] c_OP_LOAD_B    = 3'b001;
    localparam logic [2:0] c_OP_STORE     = 3'b010;
    localparam logic [2:0] c_OP_STORE_IMM = 3'b011;
    localparam logic [2:0] c_OP_JMP       = 3'b100;
    localparam logic [2:0] c_OP_RET       = 3'b110;
    localparam logic [2:0] c_OP_ALU       = 3'b111;

endpackage

`default_nettype wire

// File: rtl/ret_stack.sv
// ============================================================================
//  Module      : ret_stack
//  Description : Return-address store. With FETCH_RET_STACK_EN defined it is a
//                DEPTH-entry LIFO; otherwise a single link register + valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    if (DEPTH < 1) begin : g_depth_check
        $error("ret_stack: DEPTH must be at least 1");
    end

`ifdef FETCH_RET_STACK_EN
    localparam int c_SP_W  = $clog2(DEPTH + 1);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_SP_W-1:0]  r_sp;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = c_IDX_W'(r_sp);
    assign w_rd_idx = c_IDX_W'(r_sp - c_SP_W'(1));
    assign full     = (r_sp == c_SP_W'(DEPTH));
    assign empty    = (r_sp == '0);
    assign dout     = r_mem[w_rd_idx];

    // Push onto a full stack and pop from an empty one are silently dropped;
    // the caller flags those cases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp <= '0;
        end else if (push && !full) begin
            r_sp <= r_sp + c_SP_W'(1);
        end else if (pop && !empty) begin
            r_sp <= r_sp - c_SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            r_mem[w_wr_idx] <= din;
        end
    end
`else
    logic [W-1:0] r_link;
    logic         r_valid;

    // A new call simply overwrites the link, so the store is never full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_link  <= '0;
            r_valid <= 1'b0;
        end else if (push) begin
            r_link  <= din;
            r_valid <= 1'b1;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end

    assign dout  = r_link;
    assign full  = 1'b0;
    assign empty = ~r_valid;
`endif

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : IDLE/FETCH/EXEC instruction fetcher with call/return support.
//                FETCH_RET_STACK_EN selects a LIFO return stack over a link reg.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W        = c_PC_W_DEFAULT,
    parameter int INSTR_W     = c_INSTR_W_DEFAULT,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               fetch_req,
    output logic [PC_W-1:0]    pc,
    input  logic               instr_ready,
    input  logic [INSTR_W-1:0] instr_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    input  logic               jmp,
    input  logic               ret,
    input  logic [PC_W-1:0]    target,
    output logic               stack_err
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic [PC_W-1:0]      r_pc;
    logic [PC_W-1:0]      w_pc_nxt;
    logic [PC_W-1:0]      w_pc_inc;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_err;

    logic            w_exec;
    logic            w_jmp_only;
    logic            w_ret_only;
    logic            w_illegal;
    logic            w_push;
    logic            w_pop;
    logic            w_err_evt;
    logic [PC_W-1:0] w_stk_dout;
    logic            w_stk_full;
    logic            w_stk_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = c_ST_FETCH;
            c_ST_FETCH: w_state_nxt = instr_ready ? c_ST_EXEC : c_ST_FETCH;
            c_ST_EXEC:  w_state_nxt = c_ST_FETCH;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        fetch_req   = 1'b0;
        instr_valid = 1'b0;
        case (r_state)
            c_ST_FETCH: fetch_req   = 1'b1;
            c_ST_EXEC:  instr_valid = 1'b1;
            default: ;
        endcase
    end

    // Strobes only matter in EXEC; both high together is an illegal instruction.
    assign w_exec     = (r_state == c_ST_EXEC);
    assign w_jmp_only = jmp & ~ret;
    assign w_ret_only = ret & ~jmp;
    assign w_illegal  = jmp & ret;
    assign w_push     = w_exec & w_jmp_only & ~w_stk_full;
    assign w_pop      = w_exec & w_ret_only & ~w_stk_empty;
    assign w_err_evt  = w_exec & (w_illegal | (w_jmp_only & w_stk_full)
                                            | (w_ret_only & w_stk_empty));
    assign w_pc_inc   = r_pc + PC_W'(1);

    always_comb begin
        w_pc_nxt = r_pc;
        if (w_exec) begin
            if (w_jmp_only) begin
                w_pc_nxt = target;
            end else if (w_pop) begin
                w_pc_nxt = w_stk_dout;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_err   <= 1'b0;
        end else begin
            r_pc <= w_pc_nxt;
            if ((r_state == c_ST_FETCH) && instr_ready) begin
                r_instr <= instr_rdata;
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_stk_dout),
        .full  (w_stk_full),
        .empty (w_stk_empty)
    );

    assign pc        = r_pc;
    assign instr_out = r_instr;
    assign stack_err = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: vector table, directed
//                corner sequences and random traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fetch_req;
    logic [7:0] pc;
    logic       instr_ready = 1'b0;
    logic [7:0] instr_rdata = 8'h00;
    logic       instr_valid;
    logic [7:0] instr_out;
    logic       jmp = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] target = 8'h00;
    logic       stack_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: architectural pc, return addresses, sticky error.
    logic [7:0] m_pc;
    logic [7:0] m_stk [$];
    logic       m_err;

    fetch_unit #(
        .PC_W        (8),
        .INSTR_W     (8),
        .STACK_DEPTH (c_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .instr_ready (instr_ready),
        .instr_rdata (instr_rdata),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .jmp         (jmp),
        .ret         (ret),
        .target      (target),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 8'h00;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic j, input logic r, input logic [7:0] tgt);
        logic [7:0] nxt;
        nxt = m_pc + 8'd1;
        if (j && r) begin
            m_pc  = nxt;
            m_err = 1'b1;
        end else if (j) begin
`ifdef FETCH_RET_STACK_EN
            if (m_stk.size() < c_DEPTH) m_stk.push_back(nxt);
            else m_err = 1'b1;
`else
            m_stk.delete();
            m_stk.push_back(nxt);
`endif
            m_pc = tgt;
        end else if (r) begin
            if (m_stk.size() == 0) begin
                m_pc  = nxt;
                m_err = 1'b1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else begin
            m_pc = nxt;
        end
    endtask

    // Enter on a negedge with the DUT in IDLE/any; leave on a negedge in FETCH.
    task automatic do_reset();
        rst = 1'b1; jmp = 1'b0; ret = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_req", fetch_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_err", stack_err, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    // One instruction: stall cycles, fetch, EXEC with strobes; ends in FETCH.
    task automatic do_instr(input int stall, input logic [7:0] data, input logic j,
                            input logic r, input logic [7:0] tgt);
        for (int k = 0; k < stall; k++) begin
            instr_ready = 1'b0;
            instr_rdata = 8'($urandom);
            chk("stall_req", fetch_req, 1);
            chk("stall_pc", pc, m_pc);
            chk("stall_valid", instr_valid, 0);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        instr_rdata = data;
        chk("fetch_req", fetch_req, 1);
        chk("fetch_pc", pc, m_pc);
        chk("fetch_valid", instr_valid, 0);
        @(negedge clk);
        instr_ready = 1'($urandom_range(0, 1));
        instr_rdata = ~data;
        chk("exec_valid", instr_valid, 1);
        chk("exec_req", fetch_req, 0);
        chk("exec_instr", instr_out, data);
        jmp = j; ret = r; target = tgt;
        model_step(j, r, tgt);
        @(negedge clk);
        jmp = 1'b0; ret = 1'b0; instr_ready = 1'b0;
        chk("next_pc", pc, m_pc);
        chk("next_err", stack_err, m_err);
        chk("next_valid", instr_valid, 0);
    endtask

    typedef struct {
        int         stall;
        logic [7:0] data;
        logic       j;
        logic       r;
        logic [7:0] tgt;
        logic [7:0] exp_pc;
        logic       exp_err;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic exp_of;

        // Sequential fetch, 5-cycle stall at pc=3, then call 0x10 -> 0x40 -> ret 0x11.
        tbl[0] = '{0, 8'h11, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0};
        tbl[1] = '{0, 8'h22, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0};
        tbl[2] = '{0, 8'h33, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0};
        tbl[3] = '{5, 8'h44, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0};
        tbl[4] = '{0, 8'h95, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0};
        tbl[5] = '{0, 8'h80, 1'b1, 1'b0, 8'h40, 8'h40, 1'b0};
        tbl[6] = '{0, 8'hC0, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            do_instr(tbl[i].stall, tbl[i].data, tbl[i].j, tbl[i].r, tbl[i].tgt);
            chk("tbl_pc", pc, tbl[i].exp_pc);
            chk("tbl_err", stack_err, tbl[i].exp_err);
        end

        // Wrap: 0xFF with no strobe goes to 0x00.
        do_reset();
        do_instr(0, 8'h80, 1'b1, 1'b0, 8'hFF);
        do_instr(0, 8'hE0, 1'b0, 1'b0, 8'h00);
        chk("wrap_pc", pc, 8'h00);

        // Five nested calls: only a LIFO overflows, on the fifth, jump still taken.
        do_reset();
        for (int i = 0; i < 5; i++) begin
`ifdef FETCH_RET_STACK_EN
            exp_of = (i == 4);
`else
            exp_of = 1'b0;
`endif
            do_instr(0, 8'h80, 1'b1, 1'b0, 8'(8'h20 + 8'h10 * i));
            chk("ovf_pc", pc, 8'h20 + 8'h10 * i);
            chk("ovf_err", stack_err, exp_of);
        end

        // Return on an empty stack at 0x20, then sticky error.
        do_reset();
        for (int i = 0; i < 32; i++) do_instr(0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("udf_start_pc", pc, 8'h20);
        do_instr(0, 8'hC0, 1'b0, 1'b1, 8'h00);
        chk("udf_pc", pc, 8'h21);
        chk("udf_err", stack_err, 1);
        do_instr(1, 8'h20, 1'b0, 1'b0, 8'h00);
        chk("sticky_err", stack_err, 1);

        // Both strobes at 0x08: pc+1, no push/pop, error; later ret still finds 0x01.
        do_reset();
        do_instr(0, 8'h80, 1'b1, 1'b0, 8'h07);
        do_instr(0, 8'h00, 1'b0, 1'b0, 8'h00);
        do_instr(0, 8'h80, 1'b1, 1'b1, 8'h55);
        chk("both_pc", pc, 8'h09);
        chk("both_err", stack_err, 1);
        do_instr(0, 8'hC0, 1'b0, 1'b1, 8'h00);
        chk("both_ret_pc", pc, 8'h01);

        // Reset in EXEC with a jump strobe: abandoned, stack emptied.
        do_reset();
        do_instr(0, 8'h80, 1'b1, 1'b0, 8'h30);
        instr_ready = 1'b1; instr_rdata = 8'h85;
        @(negedge clk);
        jmp = 1'b1; target = 8'h77; rst = 1'b1;
        @(negedge clk);
        chk("rexec_pc", pc, 0);
        chk("rexec_valid", instr_valid, 0);
        chk("rexec_req", fetch_req, 0);
        chk("rexec_instr", instr_out, 0);
        chk("rexec_err", stack_err, 0);
        rst = 1'b0; jmp = 1'b0; instr_ready = 1'b0;
        model_reset();
        @(negedge clk);
        do_instr(0, 8'hC0, 1'b0, 1'b1, 8'h00);
        chk("rexec_empty_pc", pc, 8'h01);

        // Reset in FETCH with instr_ready high: nothing captured.
        instr_ready = 1'b1; instr_rdata = 8'hAB; rst = 1'b1;
        @(negedge clk);
        chk("rfetch_instr", instr_out, 0);
        chk("rfetch_pc", pc, 0);
        chk("rfetch_req", fetch_req, 0);
        rst = 1'b0; instr_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Random traffic against the model.
        for (int i = 0; i < 150; i++) begin
            do_instr($urandom_range(0, 3), 8'($urandom),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     8'($urandom));
            if ($urandom_range(0, 39) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
